// File: rtl/lzc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzc_pkg
// Brief    : Shared mode encoding and count-width helper for the LZC/normalise pipe.
// Revision : 1.0
// ============================================================================
package lzc_pkg;

    typedef enum logic {
        MODE_LZ  = 1'b0,
        MODE_SGN = 1'b1
    } lzc_mode_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzc_seg.sv
`default_nettype none
// ============================================================================
// Module   : lzc_seg
// Brief    : Single-segment leading-zero priority encoder with all-zero flag.
// Revision : 1.0
// ============================================================================
module lzc_seg
    import lzc_pkg::*;
#(
    parameter  int SEG_W  = 16,
    localparam int LCNT_W = count_width(SEG_W)
) (
    input  logic [SEG_W-1:0]  i_data,
    output logic [LCNT_W-1:0] o_cnt,
    output logic              o_zero
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        o_cnt = LCNT_W'(SEG_W);
        for (int i = 0; i < SEG_W; i++) begin
            if (i_data[i]) begin
                o_cnt = LCNT_W'(SEG_W - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzc_norm_pipe
// Brief    : Two-stage leading-zero / redundant-sign count and normalise pipe.
// Revision : 1.0
// ============================================================================
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int SEG_W  = 16,
    localparam int NSEG   = DATA_W / SEG_W,
    localparam int CNT_W  = count_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [DATA_W-1:0] out_norm,
    output logic              out_zero
);

    localparam int LCNT_W = count_width(SEG_W);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_adv;
    logic w_accept;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign in_ready = !rst && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: operand select and per-segment counting
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_sgn_x;
    logic [DATA_W-1:0] w_op;
    logic [LCNT_W-1:0] w_seg_cnt [NSEG];
    logic [NSEG-1:0]   w_seg_zero;

    // Sign mode: bit i flags a change between bits i and i+1; the MSB is
    // forced to 0 so the count includes it and is later trimmed by one.
    assign w_sgn_x = in_data ^ {in_data[DATA_W-1], in_data[DATA_W-1:1]};
    assign w_op    = (in_mode == MODE_SGN) ? {1'b0, w_sgn_x[DATA_W-2:0]} : in_data;

    generate
        for (genvar g = 0; g < NSEG; g++) begin : g_seg
            lzc_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .i_data (w_op[DATA_W-1-g*SEG_W -: SEG_W]),
                .o_cnt  (w_seg_cnt[g]),
                .o_zero (w_seg_zero[g])
            );
        end
    endgenerate

    logic [DATA_W-1:0] r_s1_data;
    lzc_mode_e         r_s1_mode;
    logic [LCNT_W-1:0] r_s1_seg_cnt [NSEG];
    logic [NSEG-1:0]   r_s1_seg_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_mode     <= MODE_LZ;
            r_s1_seg_zero <= '0;
            for (int k = 0; k < NSEG; k++) begin
                r_s1_seg_cnt[k] <= '0;
            end
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_data     <= in_data;
                r_s1_mode     <= lzc_mode_e'(in_mode);
                r_s1_seg_zero <= w_seg_zero;
                for (int k = 0; k < NSEG; k++) begin
                    r_s1_seg_cnt[k] <= w_seg_cnt[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine segment counts, normalise, register outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_raw_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_norm;
    logic              w_zero;

    // Walk from the LSB segment upward so the first non-empty segment from
    // the MSB side wins.
    always_comb begin
        w_raw_cnt = CNT_W'(DATA_W);
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (!r_s1_seg_zero[k]) begin
                w_raw_cnt = CNT_W'(k * SEG_W) + CNT_W'(r_s1_seg_cnt[k]);
            end
        end
        w_cnt  = (r_s1_mode == MODE_SGN) ? (w_raw_cnt - CNT_W'(1)) : w_raw_cnt;
        w_zero = &r_s1_seg_zero;
        w_norm = r_s1_data << w_cnt;
    end

    logic [CNT_W-1:0]  r_out_cnt;
    logic [DATA_W-1:0] r_out_norm;
    logic              r_out_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
            r_out_norm  <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            // Empty slots carry zeros so idle outputs read as 0.
            r_out_cnt   <= r_s1_valid ? w_cnt  : '0;
            r_out_norm  <= r_s1_valid ? w_norm : '0;
            r_out_zero  <= r_s1_valid && w_zero;
        end
    end

    assign out_valid = r_out_valid;
    assign out_cnt   = r_out_cnt;
    assign out_norm  = r_out_norm;
    assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzc_norm_pipe
// Brief    : Scoreboard bench for lzc_norm_pipe (DATA_W=32, SEG_W=16).
// Revision : 1.0
// ============================================================================
module tb_lzc_norm_pipe;

    localparam int DW = 32;
    localparam int CW = 6;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [DW-1:0] norm;
        logic          zero;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cnt;
    logic [DW-1:0] out_norm;
    logic          out_zero;

    lzc_norm_pipe #(
        .DATA_W (DW),
        .SEG_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_norm  (out_norm),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic mon_en  = 1'b0;
    logic rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Direct bit-walk reference, independent of the segmented datapath.
    function automatic exp_t model(input logic [DW-1:0] d, input logic m);
        exp_t e;
        int   c;
        logic run;
        c   = 0;
        run = 1'b1;
        if (!m) begin
            for (int i = DW - 1; i >= 0; i--) begin
                if (run && !d[i]) c++;
                else run = 1'b0;
            end
            e.zero = (d == '0);
        end else begin
            for (int i = DW - 2; i >= 0; i--) begin
                if (run && (d[i] == d[DW-1])) c++;
                else run = 1'b0;
            end
            e.zero = (d == '0) || (d == '1);
        end
        e.cnt  = CW'(c);
        e.norm = (c >= DW) ? '0 : (d << c);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) for it to be accepted.
    task automatic send(input logic [DW-1:0] d, input logic m);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(d, m));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [DW-1:0] d, input logic m,
                            input logic [CW-1:0] c, input logic [DW-1:0] n, input logic z);
        send(d, m);
        chk("lat_valid_c1", out_valid, 0);
        step();
        chk("lat_valid_c2", out_valid, 1);
        chk("dir_cnt", out_cnt, c);
        chk("dir_norm", out_norm, n);
        chk("dir_zero", out_zero, z);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard pops, idle-zero and stall-stability checks.
    logic          hold = 1'b0;
    logic [CW-1:0] p_cnt;
    logic [DW-1:0] p_norm;
    logic          p_zero;

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold)
                chk("stall_hold", {out_valid, out_cnt, out_norm, out_zero},
                    {1'b1, p_cnt, p_norm, p_zero});
            if (out_valid) begin
                if (out_ready && !rst) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_cnt", out_cnt, e.cnt);
                        chk("sb_norm", out_norm, e.norm);
                        chk("sb_zero", out_zero, e.zero);
                    end
                end
            end else begin
                chk("idle_zero", {out_cnt, out_norm, out_zero}, 64'd0);
            end
            hold   = out_valid && !out_ready && !rst;
            p_cnt  = out_cnt;
            p_norm = out_norm;
            p_zero = out_zero;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [DW-1:0] d;
        int            sh;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
        end
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        step();

        // Directed values with exact two-cycle latency.
        out_ready = 1'b1;
        directed(32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0);
        directed(32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1);
        directed(32'hFFFF_8000, 1'b1, 6'd16, 32'h8000_0000, 1'b0);
        directed(32'hFFFF_FFFF, 1'b1, 6'd31, 32'h8000_0000, 1'b1);
        directed(32'h0000_0000, 1'b1, 6'd31, 32'h0000_0000, 1'b1);
        directed(32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0);
        directed(32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0);
        directed(32'h4000_0000, 1'b1, 6'd0,  32'h4000_0000, 1'b0);
        step();

        // Back-to-back mode alternation with no bubble.
        send(32'h0000_00F0, 1'b1);
        send(32'h0000_00F0, 1'b0);
        send(32'hFFF0_0000, 1'b1);
        send(32'hFFF0_0000, 1'b0);
        drain();

        // A,B accepted under stall, C held off until release.
        out_ready = 1'b0;
        send(32'h0012_3456, 1'b0);
        send(32'hFFFE_1234, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_0100;
        in_mode  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        send(32'h0000_0100, 1'b0);
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(32'h0000_0F00, 1'b0);
        send(32'h0F00_0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hold_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_flush_out_valid", out_valid, 0);
        chk("rst_flush_in_ready", in_ready, 1);
        step();
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("no_stale_out", out_valid, 0);
        end

        // Random mixed-mode stream with random backpressure.
        rnd_rdy = 1'b1;
        for (int b = 0; b < 300; b++) begin
            d  = $urandom;
            sh = $urandom_range(0, 32);
            d  = (sh == 32) ? '0 : (d >> sh);
            if ($urandom_range(0, 1) == 1) d = ~d;
            send(d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) step();
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
